// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reverse sharing controller.
package bitrev_pkg;

    localparam int BR_WIDTH = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Mirror a word so that bit k lands on bit BR_WIDTH-1-k.
    function automatic logic [BR_WIDTH-1:0] bit_reverse(input logic [BR_WIDTH-1:0] word);
        logic [BR_WIDTH-1:0] rev;
        rev = '0;
        for (int k = 0; k < BR_WIDTH; k++) begin
            rev[k] = word[BR_WIDTH-1-k];
        end
        return rev;
    endfunction

endpackage

// File: rtl/bitrev_share_ctrl_rr_pick.sv
// Round-robin picker: finds the first active request at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any_req
);

    // Scan from the farthest offset down so the nearest active request to ptr wins last.
    always_comb begin
        int cand;
        grant   = '0;
        idx     = '0;
        cand    = 0;
        any_req = |req;
        for (int off = N - 1; off >= 0; off--) begin
            cand = (int'(ptr) + off) % N;
            if (req[cand]) begin
                idx = IDW'(cand);
            end
        end
        if (any_req) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bitrev_share_ctrl.sv
// Shares one bit-reverse datapath among N_REQ requesters with round-robin arbitration
// and a single backpressured response register.
module bitrev_share_ctrl
    import bitrev_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = BR_WIDTH,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_rev,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic [15:0]            busy_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   win;
    logic             any_req;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_rev;

    rr_pick #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .grant   (grant),
        .idx     (win),
        .any_req (any_req)
    );

    assign accept    = !rst && any_req && (state == ST_EMPTY || rsp_ready);
    assign req_ready = accept ? grant : '0;
    assign rsp_valid = (state == ST_FULL);
    assign sel_data  = req_data[int'(win)*WIDTH +: WIDTH];
    assign sel_rev   = req_rev[win];

    // State register for the output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Slot fills on accept, drains when consumed with nothing new arriving.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL:  if (rsp_ready && !accept) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Capture the winner's processed word and advance pointer and counter on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            ptr      <= '0;
            busy_cnt <= '0;
        end else if (accept) begin
            rsp_data <= sel_rev ? bit_reverse(sel_data) : sel_data;
            rsp_id   <= win;
            ptr      <= (win == IDW'(N_REQ - 1)) ? '0 : win + IDW'(1);
            busy_cnt <= busy_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_bitrev_share_ctrl.sv
// Self-checking bench for bitrev_share_ctrl against a behavioural reference model.
module tb_bitrev_share_ctrl;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [3:0]   req_rev;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic [15:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          mvalid;
    logic [31:0] mdata;
    int          mid;
    int          mptr;
    int          mcnt;
    bit          fixed_data;

    bitrev_share_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_rev   (req_rev),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy_cnt  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reversal built by shifting bits in LSB-first, so the first bit read ends at the MSB.
    function automatic logic [31:0] rev32(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r = {r[30:0], d[k]};
        return r;
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_ready);
        chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, exp_ready});
        chk({tag, "_valid"}, {31'd0, rsp_valid}, {31'd0, mvalid});
        if (mvalid) begin
            chk({tag, "_data"}, rsp_data, mdata);
            chk({tag, "_id"}, {30'd0, rsp_id}, mid);
        end
        chk({tag, "_cnt"}, {16'd0, busy_cnt}, mcnt);
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [3:0] rv,
                                 input logic rr);
        rst       = r;
        req_valid = v;
        req_rev   = rv;
        rsp_ready = rr;
    endtask

    // One clock: compare at the falling edge, advance the model, then move past the rising edge.
    task automatic cycle(input string tag);
        int   w;
        logic acc;
        @(negedge clk);
        w   = pick();
        acc = !rst && (w >= 0) && (!mvalid || rsp_ready);
        checkOutput(tag, acc ? (4'b0001 << w) : 4'b0000);
        if (rst) begin
            mvalid = 0; mdata = '0; mid = 0; mptr = 0; mcnt = 0;
        end else if (acc) begin
            mvalid = 1;
            mdata  = req_rev[w] ? rev32(req_data[w*32 +: 32]) : req_data[w*32 +: 32];
            mid    = w;
            mptr   = (w + 1) % N;
            mcnt   = (mcnt + 1) % 65536;
        end else if (rsp_ready) begin
            mvalid = 0;
        end
        @(posedge clk);
        #1;
        if (acc && !fixed_data) req_data[w*32 +: 32] = $urandom();
    endtask

    initial begin
        fixed_data = 1;
        mvalid = 0; mdata = '0; mid = 0; mptr = 0; mcnt = 0;
        req_data = '0;
        applyStimulus(1'b1, 4'hF, 4'h0, 1'b0);
        @(posedge clk);
        #1;

        // Reset held with all requests asserted
        cycle("reset0");
        cycle("reset1");

        // Single request, reversed then passed through
        req_data[31:0] = 32'h0000_0001;
        applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b1);
        cycle("single_rev");
        chk("single_rev_word", rsp_data, 32'h8000_0000);
        chk("single_rev_id", {30'd0, rsp_id}, 32'd0);
        applyStimulus(1'b0, 4'b0001, 4'b0000, 1'b1);
        cycle("single_pass");
        chk("single_pass_word", rsp_data, 32'h0000_0001);

        // Round-robin with all requesters active
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b1);
        cycle("rr_reset");
        req_data = {4{32'h1234_5678}};
        applyStimulus(1'b0, 4'hF, 4'hF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cycle("rr");
            chk("rr_id_seq", {30'd0, rsp_id}, k % 4);
            chk("rr_word", rsp_data, 32'h1E6A_2C48);
        end

        // Backpressure with requests pending, then release
        fixed_data = 0;
        for (int i = 0; i < N; i++) req_data[i*32 +: 32] = $urandom();
        applyStimulus(1'b0, 4'hF, 4'hA, 1'b0);
        for (int k = 0; k < 5; k++) cycle("bp_hold");
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle("bp_release");

        // Reset while a response is held
        applyStimulus(1'b0, 4'hF, 4'h5, 1'b0);
        cycle("hold_fill");
        cycle("hold_keep");
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        applyStimulus(1'b1, 4'hF, 4'h5, 1'b0);
        cycle("midreset");
        chk("midreset_valid", {31'd0, rsp_valid}, 32'd0);
        applyStimulus(1'b0, 4'b0110, 4'h0, 1'b1);
        cycle("post_reset");
        chk("post_reset_id", {30'd0, rsp_id}, 32'd1);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 4'($urandom()), 4'($urandom()),
                          1'($urandom()));
            cycle("rand");
        end

        // Counter wrap: 65535 accepts, then one more
        applyStimulus(1'b1, 4'h0, 4'h0, 1'b1);
        cycle("wrap_reset");
        applyStimulus(1'b0, 4'hF, 4'h0, 1'b1);
        for (int n = 0; n < 65535; n++) begin
            req_rev = 4'($urandom());
            cycle("wrap");
        end
        chk("cnt_full", {16'd0, busy_cnt}, 32'h0000_FFFF);
        cycle("wrap_last");
        chk("cnt_wrap", {16'd0, busy_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
